apb_master_mc: RTL and testbench
================================

Name: apb_master_mc

Overview:
- Parametrised APB4 master, the next generation of the single-slave apb_master. Generalised in address/data width and slave count.
- Accepts transfers on a valid/ready command port and decodes one of NUM_SLV PSEL lines from address bits.
- Drives the APB SETUP/ACCESS protocol with PSTRB and returns read data/error on a valid/ready response port.
- Sits between the round-robin interconnect arbiter and the APB slave bank.

Parameters:
ADDR_W, 32, PADDR/cmd_addr width
DATA_W, 32, PWDATA/PRDATA width (multiple of 8); STRB_W = DATA_W/8
NUM_SLV, 4, number of PSEL outputs (1..16, need not be power of two)
SEL_LSB, 12, LSB of slave-index field; index = cmd_addr[SEL_LSB +: max(1,$clog2(NUM_SLV))]
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (>=2)

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  STRB_W  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  PSLVERR, decode error or timeout
rsp_timeout  out  1  error cause was timeout
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PWRITE  out  1  APB direction
PSTRB  out  STRB_W  APB strobes (0 on reads)
PSEL  out  NUM_SLV  one-hot slave select
PENABLE  out  1  APB access phase
PRDATA  in  DATA_W  muxed read data from selected slave
PREADY  in  1  muxed ready
PSLVERR  in  1  muxed error

Behaviour:
- Reset (async, PRESET=1): state IDLE; all outputs 0, including cmd_ready, PSEL, PENABLE, PADDR, PWDATA, PSTRB, rsp_*. In-flight transfer dropped, no response. Timeout counter cleared.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1. On cmd_valid, register addr/wdata/strb/write and decode index.
  - Index < NUM_SLV -> SETUP.
  - Index >= NUM_SLV -> RESP with rsp_err=1, rdata=0, no APB activity (decode error).
- SETUP (1 cycle): PSEL[index]=1, PENABLE=0, PADDR/PWDATA/PWRITE/PSTRB driven from registered command -> ACCESS.
- ACCESS:
  - PSEL held, PENABLE=1; all APB outputs stable until PREADY.
  - On PREADY=1: capture PRDATA if read (0 if write); rsp_err=PSLVERR; PSEL/PENABLE drop next cycle; -> RESP.
  - PSLVERR is sampled only when PREADY=1.
- RESP: rsp_valid=1; rsp_* stable until rsp_ready=1, then -> IDLE. rsp_ready has no effect when rsp_valid=0.
- cmd_ready=0 in SETUP/ACCESS/RESP (single outstanding transfer).
- Minimum latency: accept (cycle 0) -> SETUP (1) -> ACCESS (2) -> rsp_valid (3) with zero wait states.
- Back-to-back throughput: 4 cycles/transfer when rsp_ready is held high.
- Outside a transfer, PADDR/PWDATA/PWRITE hold their last values; PSTRB=0.

Optional Feature:
APB_MASTER_TIMEOUT_EN:
- Defined: a counter increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT, PSEL/PENABLE drop, -> RESP with rsp_err=1, rsp_timeout=1, rdata=0. The counter clears on entry to SETUP.
- Undefined: ACCESS waits indefinitely; rsp_timeout tied 0; no counter logic.

Test Plan:
- Write, addr 0x0000_1004, wdata 0xDEAD_BEEF, strb 0xF, PREADY=1 immediately -> PSEL=4'b0010 in SETUP, PENABLE only in ACCESS, PSTRB=0xF, rsp_valid at cycle 3, rsp_err=0, rsp_rdata=0.
- Read, addr 0x0000_3010, PRDATA=0xABCD_EF01, PREADY after 3 wait cycles -> PSEL=4'b1000, PADDR stable across all waits, rsp_rdata=0xABCD_EF01, PSTRB=0.
- Read with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0; rsp held 5 cycles with rsp_ready=0, then IDLE and cmd_ready=1.
- NUM_SLV=3, addr 0x0000_3000 -> no PSEL/PENABLE ever, rsp_valid 1 cycle after accept, rsp_err=1.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT=16, PREADY stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; without the macro, still in ACCESS at cycle 100.
- PRESET asserted mid-ACCESS -> PSEL/PENABLE/rsp_valid 0 in the same cycle, no response after release, next command completes normally.

Source files
------------

// File: rtl/apb_master_mc_if.sv
// Command/response handshake and APB bus bundle for apb_master_mc.
// The master modport is the controller's view; the slave modport is the far side.
interface apb_master_mc_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4
);
   localparam int STRB_W = DATA_W / 8;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_strb;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic [ADDR_W-1:0]  PADDR;
   logic [DATA_W-1:0]  PWDATA;
   logic               PWRITE;
   logic [STRB_W-1:0]  PSTRB;
   logic [NUM_SLV-1:0] PSEL;
   logic               PENABLE;
   logic [DATA_W-1:0]  PRDATA;
   logic               PREADY;
   logic               PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE
   );
endinterface

// File: rtl/apb_master_mc.sv
// Parametrised APB4 master with address-decoded PSEL fan-out, one transfer in flight.
// Optional ACCESS wait-state abort is enabled by defining APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL asserted, PENABLE low, one cycle
// ACCESS | PSEL and PENABLE high until PREADY (or timeout)
// RESP   | rsp_valid high until rsp_ready
module apb_master_mc #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4,
   parameter int SEL_LSB = 12,
   parameter int TIMEOUT = 16
) (
   input logic PCLK,
   input logic PRESET,
   apb_master_mc_if.master bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam logic [SEL_W:0] NUM_SLV_L = (SEL_W + 1)'(NUM_SLV);

   if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
      $error("apb_master_mc: NUM_SLV must be 1..16");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("apb_master_mc: TIMEOUT must be >= 2");
   end
   if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("apb_master_mc: DATA_W must be a multiple of 8");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] strb_q;
   logic              write_q;
   logic [SEL_W-1:0]  sel_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              rsp_tmo_q;

   logic [SEL_W-1:0] sel_idx;
   logic             sel_ok;
   logic             accept;
   logic             done;
   logic             tmo_hit;
   logic             apb_on;

   assign sel_idx = bus.cmd_addr[SEL_LSB +: SEL_W];
   assign sel_ok  = ({1'b0, sel_idx} < NUM_SLV_L);
   assign accept  = (state == IDLE) && !PRESET && bus.cmd_valid;
   assign done    = (state == ACCESS) && bus.PREADY;
   assign apb_on  = (state == SETUP) || (state == ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0] tmo_cnt;

   // Down-counter loaded in SETUP; terminal count on the TIMEOUT-th stalled ACCESS cycle.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tmo_cnt <= '0;
      end else if (state == SETUP) begin
         tmo_cnt <= CNT_W'(TIMEOUT - 1);
      end else if ((state == ACCESS) && !bus.PREADY && (tmo_cnt != '0)) begin
         tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   assign tmo_hit = (state == ACCESS) && !bus.PREADY && (tmo_cnt == '0);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = sel_ok ? SETUP : RESP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done || tmo_hit) state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         strb_q      <= '0;
         write_q     <= 1'b0;
         sel_q       <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_tmo_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q      <= bus.cmd_addr;
            wdata_q     <= bus.cmd_wdata;
            strb_q      <= bus.cmd_strb;
            write_q     <= bus.cmd_write;
            sel_q       <= sel_idx;
            rsp_rdata_q <= '0;
            rsp_err_q   <= !sel_ok;
            rsp_tmo_q   <= 1'b0;
         end
         if (done) begin
            // Read data is only returned for error-free reads.
            rsp_rdata_q <= (!write_q && !bus.PSLVERR) ? bus.PRDATA : '0;
            rsp_err_q   <= bus.PSLVERR;
            rsp_tmo_q   <= 1'b0;
         end else if (tmo_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_tmo_q   <= 1'b1;
         end
         if ((state == RESP) && bus.rsp_ready) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.cmd_ready = (state == IDLE) && !PRESET;
      bus.rsp_valid = (state == RESP);
      bus.rsp_rdata = rsp_rdata_q;
      bus.rsp_err   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
      bus.rsp_timeout = rsp_tmo_q;
`else
      bus.rsp_timeout = 1'b0;
`endif
      bus.PADDR   = addr_q;
      bus.PWDATA  = wdata_q;
      bus.PWRITE  = write_q;
      bus.PSTRB   = (apb_on && write_q) ? strb_q : '0;
      bus.PENABLE = (state == ACCESS);
      bus.PSEL    = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         bus.PSEL[i] = apb_on && (sel_q == SEL_W'(i));
      end
   end

`ifndef APB_MASTER_TIMEOUT_EN
   logic unused_tmo;
   assign unused_tmo = rsp_tmo_q;
`endif
endmodule

// File: tb/tb_apb_master_mc.sv
// Directed bench for apb_master_mc: a 4-slave instance for the main sequence
// and a 3-slave instance for the decode-error case.
module tb_apb_master_mc;
   logic PCLK = 1'b0;
   logic PRESET;
   int   vectors = 0;
   int   errs    = 0;

   always #5 PCLK = ~PCLK;

   apb_master_mc_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus4 ();
   apb_master_mc_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) bus3 ();

   apb_master_mc #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SEL_LSB(12), .TIMEOUT(16))
      dut4 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus4));
   apb_master_mc #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SEL_LSB(12), .TIMEOUT(16))
      dut3 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus3));

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmd4(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb);
      bus4.cmd_valid = 1'b1;
      bus4.cmd_write = wr;
      bus4.cmd_addr  = addr;
      bus4.cmd_wdata = wd;
      bus4.cmd_strb  = strb;
      tick();
      bus4.cmd_valid = 1'b0;
   endtask

   initial begin
      PRESET = 1'b1;
      bus4.cmd_valid = 1'b0; bus4.cmd_write = 1'b0; bus4.cmd_addr = '0;
      bus4.cmd_wdata = '0;   bus4.cmd_strb = '0;    bus4.rsp_ready = 1'b0;
      bus4.PRDATA = '0;      bus4.PREADY = 1'b0;    bus4.PSLVERR = 1'b0;
      bus3.cmd_valid = 1'b0; bus3.cmd_write = 1'b0; bus3.cmd_addr = '0;
      bus3.cmd_wdata = '0;   bus3.cmd_strb = '0;    bus3.rsp_ready = 1'b0;
      bus3.PRDATA = '0;      bus3.PREADY = 1'b1;    bus3.PSLVERR = 1'b0;

      // Reset values
      tick(); tick();
      chk("rst_cmd_ready", 64'(bus4.cmd_ready), 64'd0);
      chk("rst_psel",      64'(bus4.PSEL),      64'd0);
      chk("rst_penable",   64'(bus4.PENABLE),   64'd0);
      chk("rst_paddr",     64'(bus4.PADDR),     64'd0);
      chk("rst_pwdata",    64'(bus4.PWDATA),    64'd0);
      chk("rst_rsp_valid", 64'(bus4.rsp_valid), 64'd0);
      PRESET = 1'b0;
      tick();
      chk("idle_cmd_ready", 64'(bus4.cmd_ready), 64'd1);

      // Zero-wait write to slave 1
      bus4.PREADY = 1'b1;
      cmd4(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
      chk("wr_setup_psel",    64'(bus4.PSEL),      64'b0010);
      chk("wr_setup_penable", 64'(bus4.PENABLE),   64'd0);
      chk("wr_setup_paddr",   64'(bus4.PADDR),     64'h1004);
      chk("wr_setup_pwdata",  64'(bus4.PWDATA),    64'hDEAD_BEEF);
      chk("wr_setup_pwrite",  64'(bus4.PWRITE),    64'd1);
      chk("wr_setup_pstrb",   64'(bus4.PSTRB),     64'hF);
      chk("wr_setup_ready",   64'(bus4.cmd_ready), 64'd0);
      tick();
      chk("wr_acc_psel",    64'(bus4.PSEL),      64'b0010);
      chk("wr_acc_penable", 64'(bus4.PENABLE),   64'd1);
      chk("wr_acc_rvalid",  64'(bus4.rsp_valid), 64'd0);
      tick();
      chk("wr_rsp_valid",   64'(bus4.rsp_valid), 64'd1);
      chk("wr_rsp_err",     64'(bus4.rsp_err),   64'd0);
      chk("wr_rsp_rdata",   64'(bus4.rsp_rdata), 64'd0);
      chk("wr_rsp_psel",    64'(bus4.PSEL),      64'd0);
      chk("wr_rsp_penable", 64'(bus4.PENABLE),   64'd0);
      chk("wr_rsp_pstrb",   64'(bus4.PSTRB),     64'd0);
      chk("wr_rsp_paddr",   64'(bus4.PADDR),     64'h1004);
      bus4.rsp_ready = 1'b1;
      tick();
      bus4.rsp_ready = 1'b0;
      chk("wr_done_valid", 64'(bus4.rsp_valid), 64'd0);
      chk("wr_done_ready", 64'(bus4.cmd_ready), 64'd1);

      // Read from slave 3 with three wait states
      bus4.PREADY = 1'b0;
      bus4.PRDATA = 32'hABCD_EF01;
      cmd4(1'b0, 32'h0000_3010, 32'h1111_2222, 4'hF);
      chk("rd_setup_psel",   64'(bus4.PSEL),   64'b1000);
      chk("rd_setup_pstrb",  64'(bus4.PSTRB),  64'd0);
      chk("rd_setup_pwrite", 64'(bus4.PWRITE), 64'd0);
      tick();
      for (int w = 0; w < 3; w++) begin
         chk("rd_wait_paddr",   64'(bus4.PADDR),     64'h3010);
         chk("rd_wait_penable", 64'(bus4.PENABLE),   64'd1);
         chk("rd_wait_psel",    64'(bus4.PSEL),      64'b1000);
         chk("rd_wait_rvalid",  64'(bus4.rsp_valid), 64'd0);
         tick();
      end
      bus4.PREADY = 1'b1;
      chk("rd_last_paddr", 64'(bus4.PADDR), 64'h3010);
      tick();
      chk("rd_rsp_valid", 64'(bus4.rsp_valid), 64'd1);
      chk("rd_rsp_rdata", 64'(bus4.rsp_rdata), 64'hABCD_EF01);
      chk("rd_rsp_err",   64'(bus4.rsp_err),   64'd0);
      bus4.rsp_ready = 1'b1;
      tick();
      bus4.rsp_ready = 1'b0;

      // Read with PSLVERR, response held under backpressure
      bus4.PRDATA  = 32'h1234_5678;
      bus4.PSLVERR = 1'b1;
      cmd4(1'b0, 32'h0000_2000, 32'h0, 4'h0);
      chk("err_setup_psel", 64'(bus4.PSEL), 64'b0100);
      tick();
      tick();
      bus4.PSLVERR = 1'b0;
      for (int h = 0; h < 5; h++) begin
         chk("err_hold_valid", 64'(bus4.rsp_valid),   64'd1);
         chk("err_hold_err",   64'(bus4.rsp_err),     64'd1);
         chk("err_hold_tmo",   64'(bus4.rsp_timeout), 64'd0);
         chk("err_hold_rdata", 64'(bus4.rsp_rdata),   64'd0);
         chk("err_hold_ready", 64'(bus4.cmd_ready),   64'd0);
         tick();
      end
      bus4.rsp_ready = 1'b1;
      tick();
      bus4.rsp_ready = 1'b0;
      chk("err_done_valid", 64'(bus4.rsp_valid), 64'd0);
      chk("err_done_ready", 64'(bus4.cmd_ready), 64'd1);

      // Decode error on the 3-slave instance
      bus3.cmd_valid = 1'b1;
      bus3.cmd_write = 1'b0;
      bus3.cmd_addr  = 32'h0000_3000;
      chk("dec_accept_psel", 64'(bus3.PSEL), 64'd0);
      tick();
      bus3.cmd_valid = 1'b0;
      chk("dec_rsp_valid", 64'(bus3.rsp_valid), 64'd1);
      chk("dec_rsp_err",   64'(bus3.rsp_err),   64'd1);
      chk("dec_rsp_rdata", 64'(bus3.rsp_rdata), 64'd0);
      chk("dec_psel",      64'(bus3.PSEL),      64'd0);
      chk("dec_penable",   64'(bus3.PENABLE),   64'd0);
      bus3.rsp_ready = 1'b1;
      tick();
      bus3.rsp_ready = 1'b0;
      chk("dec_done_ready", 64'(bus3.cmd_ready), 64'd1);
      chk("dec_done_psel",  64'(bus3.PSEL),      64'd0);

      // Stuck PREADY
      bus4.PREADY = 1'b0;
      cmd4(1'b0, 32'h0000_0000, 32'h0, 4'h0);
      tick();
`ifdef APB_MASTER_TIMEOUT_EN
      for (int k = 0; k < 16; k++) begin
         chk("tmo_wait_penable", 64'(bus4.PENABLE),   64'd1);
         chk("tmo_wait_rvalid",  64'(bus4.rsp_valid), 64'd0);
         tick();
      end
      chk("tmo_rsp_valid", 64'(bus4.rsp_valid),   64'd1);
      chk("tmo_rsp_err",   64'(bus4.rsp_err),     64'd1);
      chk("tmo_rsp_tmo",   64'(bus4.rsp_timeout), 64'd1);
      chk("tmo_rsp_rdata", 64'(bus4.rsp_rdata),   64'd0);
      chk("tmo_psel",      64'(bus4.PSEL),        64'd0);
      bus4.rsp_ready = 1'b1;
      tick();
      bus4.rsp_ready = 1'b0;
      cmd4(1'b0, 32'h0000_0000, 32'h0, 4'h0);
      tick();
      chk("rst_pre_penable", 64'(bus4.PENABLE), 64'd1);
`else
      // Cycle 2 is the first ACCESS cycle; run on to cycle 100.
      for (int k = 2; k < 100; k++) begin
         tick();
      end
      chk("hang_penable",   64'(bus4.PENABLE),     64'd1);
      chk("hang_psel",      64'(bus4.PSEL),        64'b0001);
      chk("hang_rvalid",    64'(bus4.rsp_valid),   64'd0);
      chk("hang_rsp_tmo",   64'(bus4.rsp_timeout), 64'd0);
`endif

      // Reset mid-ACCESS: outputs drop within the same cycle
      #3;
      PRESET = 1'b1;
      #1;
      chk("mid_rst_psel",    64'(bus4.PSEL),      64'd0);
      chk("mid_rst_penable", 64'(bus4.PENABLE),   64'd0);
      chk("mid_rst_rvalid",  64'(bus4.rsp_valid), 64'd0);
      chk("mid_rst_ready",   64'(bus4.cmd_ready), 64'd0);
      tick();
      PRESET = 1'b0;
      bus4.PREADY = 1'b1;
      for (int r = 0; r < 3; r++) begin
         tick();
         chk("post_rst_rvalid", 64'(bus4.rsp_valid), 64'd0);
         chk("post_rst_psel",   64'(bus4.PSEL),      64'd0);
      end
      chk("post_rst_ready", 64'(bus4.cmd_ready), 64'd1);
      cmd4(1'b1, 32'h0000_1000, 32'h5555_AAAA, 4'b0011);
      chk("post_setup_psel",  64'(bus4.PSEL),  64'b0010);
      chk("post_setup_pstrb", 64'(bus4.PSTRB), 64'b0011);
      tick();
      chk("post_acc_penable", 64'(bus4.PENABLE), 64'd1);
      tick();
      chk("post_rsp_valid", 64'(bus4.rsp_valid),   64'd1);
      chk("post_rsp_err",   64'(bus4.rsp_err),     64'd0);
      chk("post_rsp_tmo",   64'(bus4.rsp_timeout), 64'd0);
      bus4.rsp_ready = 1'b1;
      tick();
      bus4.rsp_ready = 1'b0;
      chk("post_done_ready", 64'(bus4.cmd_ready), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
